// File: rtl/mux_rr_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_rr_arbiter_if : request/data/handshake bundle for mux_rr_arbiter (rev 1.0)
// ---------------------------------------------------------------------------
interface mux_rr_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       req;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [WIDTH-1:0] data3;
  logic             out_ready;
  logic [3:0]       ack;
  logic [1:0]       sel;
  logic [3:0]       grant;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  modport master (
    output req, data0, data1, data2, data3, out_ready,
    input  ack, sel, grant, out_valid, out_data
  );

  modport slave (
    input  req, data0, data1, data2, data3, out_ready,
    output ack, sel, grant, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_rr_arbiter : round-robin 4:1 registered mux with valid/ready out (rev 1.0)
// ---------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  mux_rr_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_sel;
  logic [3:0]       r_grant;
  logic [3:0]       r_ack;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;

  logic             w_hs;
  logic [1:0]       w_base;
  logic [1:0]       w_cand;
  logic             w_found;
  logic [1:0]       w_win;
  logic             w_capture;
  logic [WIDTH-1:0] w_data;
  logic [3:0]       w_onehot;

  assign w_hs = r_out_valid & bus.out_ready;
  // The handshake cycle already arbitrates with the rotated priority.
  assign w_base    = w_hs ? (r_sel + 2'd1) : r_ptr;
  assign w_capture = w_found & ((r_state == IDLE) | w_hs);
  assign w_onehot  = 4'b0001 << w_win;

  // Scan from highest to lowest distance so the nearest request wins last.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_cand  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      w_cand = w_base + 2'(k);
      if (bus.req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_data = bus.data0;
    case (w_win)
      2'd0:    w_data = bus.data0;
      2'd1:    w_data = bus.data1;
      2'd2:    w_data = bus.data2;
      default: w_data = bus.data3;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= 2'd0;
      r_sel       <= 2'd0;
      r_grant     <= 4'd0;
      r_ack       <= 4'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_ack <= 4'd0;
      if (w_hs) begin
        r_ptr <= w_base;
      end
      if (w_capture) begin
        r_out_data  <= w_data;
        r_sel       <= w_win;
        r_grant     <= w_onehot;
        r_ack       <= w_onehot;
        r_out_valid <= 1'b1;
        r_state     <= BUSY;
      end else if (w_hs) begin
        // Drained with nobody waiting: sel and out_data keep their last values.
        r_out_valid <= 1'b0;
        r_grant     <= 4'd0;
        r_state     <= IDLE;
      end
    end
  end

  assign bus.ack       = r_ack;
  assign bus.sel       = r_sel;
  assign bus.grant     = r_grant;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mux_rr_arbiter : directed + random bench with behavioural model (rev 1.0)
// ---------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mux_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: one transfer slot plus a rotating priority pointer.
  bit        m_valid;
  int        m_data;
  int        m_sel;
  int        m_grant;
  int        m_ack;
  int        m_ptr;

  always @(posedge clk or posedge rst) begin
    int  words[4];
    int  start;
    int  w;
    bit  hs;
    if (rst) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_grant = 0; m_ack = 0; m_ptr = 0;
    end else begin
      words[0] = int'(bus.data0);
      words[1] = int'(bus.data1);
      words[2] = int'(bus.data2);
      words[3] = int'(bus.data3);
      hs    = m_valid && bus.out_ready;
      start = hs ? (m_sel + 1) % 4 : m_ptr;
      if (hs) m_ptr = start;
      w = -1;
      for (int k = 0; k < 4; k++) begin
        if (w < 0 && bus.req[(start + k) % 4]) w = (start + k) % 4;
      end
      m_ack = 0;
      if (!m_valid || hs) begin
        if (w >= 0) begin
          m_valid = 1;
          m_data  = words[w];
          m_sel   = w;
          m_grant = 1 << w;
          m_ack   = 1 << w;
        end else if (hs) begin
          m_valid = 0;
          m_grant = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("model out_data",  32'(bus.out_data),  32'(m_data));
      chk("model sel",       32'(bus.sel),       32'(m_sel));
      chk("model grant",     32'(bus.grant),     32'(m_grant));
      chk("model ack",       32'(bus.ack),       32'(m_ack));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [WIDTH-1:0] d,
                            input logic [1:0] s, input logic [3:0] g, input logic [3:0] a);
    chk({name, " out_valid"}, 32'(bus.out_valid), 32'(v));
    chk({name, " out_data"},  32'(bus.out_data),  32'(d));
    chk({name, " sel"},       32'(bus.sel),       32'(s));
    chk({name, " grant"},     32'(bus.grant),     32'(g));
    chk({name, " ack"},       32'(bus.ack),       32'(a));
  endtask

  task automatic set_in(input logic [3:0] r, input logic rdy);
    bus.req       = r;
    bus.out_ready = rdy;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req = 4'd0; bus.out_ready = 1'b0;
    bus.data0 = 4'h0; bus.data1 = 4'h0; bus.data2 = 4'h0; bus.data3 = 4'h0;
    tick(); tick();
    expect_out("reset", 1'b0, 4'h0, 2'd0, 4'b0000, 4'b0000);
    rst = 1'b0;

    // Single word from requester 0
    bus.data0 = 4'hA;
    set_in(4'b0001, 1'b1);
    tick();
    expect_out("t1 capture", 1'b1, 4'hA, 2'd0, 4'b0001, 4'b0001);
    set_in(4'b0000, 1'b1);
    tick();
    chk("t1 drain out_valid", 32'(bus.out_valid), 32'd0);
    chk("t1 drain ack", 32'(bus.ack), 32'd0);

    // All four requesting, fresh priority: 5,6,7,8,5
    rst = 1'b1; tick(); rst = 1'b0;
    bus.data0 = 4'd5; bus.data1 = 4'd6; bus.data2 = 4'd7; bus.data3 = 4'd8;
    set_in(4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("t2 rotate", 1'b1, 4'(5 + i % 4), 2'(i % 4), 4'(1 << (i % 4)), 4'(1 << (i % 4)));
    end
    set_in(4'b0000, 1'b1);
    tick();
    chk("t2 drain out_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure on requester 2
    bus.data2 = 4'hC;
    set_in(4'b0100, 1'b0);
    tick();
    expect_out("t3 capture", 1'b1, 4'hC, 2'd2, 4'b0100, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("t3 hold", 1'b1, 4'hC, 2'd2, 4'b0100, 4'b0000);
    end
    set_in(4'b0000, 1'b1);
    tick();
    expect_out("t3 release", 1'b0, 4'hC, 2'd2, 4'b0000, 4'b0000);

    // Fairness between 0 and 3 starting with pointer at 3
    set_in(4'b1001, 1'b1);
    tick(); chk("t4 win a", 32'(bus.sel), 32'd3);
    tick(); chk("t4 win b", 32'(bus.sel), 32'd0);
    tick(); chk("t4 win c", 32'(bus.sel), 32'd3);
    tick(); chk("t4 win d", 32'(bus.sel), 32'd0);
    set_in(4'b0000, 1'b1);
    tick();
    chk("t4 drain out_valid", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset while BUSY
    bus.data0 = 4'h3;
    set_in(4'b0001, 1'b0);
    tick();
    chk("t5 busy out_valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    expect_out("t5 async rst", 1'b0, 4'h0, 2'd0, 4'b0000, 4'b0000);
    rst = 1'b0;
    bus.data1 = 4'h9; bus.data3 = 4'h4;
    set_in(4'b1010, 1'b1);
    tick();
    expect_out("t5 after rst", 1'b1, 4'h9, 2'd1, 4'b0010, 4'b0010);
    set_in(4'b0000, 1'b1);
    tick();

    // Idle gap then wrap 3->0
    bus.data2 = 4'h7;
    set_in(4'b0100, 1'b1);
    tick();
    chk("t6 sel 2", 32'(bus.sel), 32'd2);
    set_in(4'b0000, 1'b1);
    tick(); tick(); tick();
    chk("t6 gap out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6 gap sel kept", 32'(bus.sel), 32'd2);
    bus.data0 = 4'hE;
    set_in(4'b0101, 1'b1);
    tick();
    expect_out("t6 wrap", 1'b1, 4'hE, 2'd0, 4'b0001, 4'b0001);

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      bus.req       = 4'($urandom_range(0, 15));
      bus.data0     = 4'($urandom);
      bus.data1     = 4'($urandom);
      bus.data2     = 4'($urandom);
      bus.data3     = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1; #1; rst = 1'b0;
      end
      tick();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter sharing one registered 4:1 datapath mux among four requesters.
- Picks a winner, drives the select, captures the winner's WIDTH-bit word into an output register, and presents it downstream with a valid/ready handshake.
- Sits between four producer blocks and one shared consumer.

Parameters:
WIDTH, 4, data word width per requester and of out_data.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
req  input  4  per-requester request; req[i] means data_i holds a valid word
data0  input  WIDTH  requester 0 word
data1  input  WIDTH  requester 1 word
data2  input  WIDTH  requester 2 word
data3  input  WIDTH  requester 3 word
out_ready  input  1  downstream can accept out_data this cycle
ack  output  4  one-hot, registered; one-cycle pulse when requester i's word is captured
sel  output  2  registered index of the current or last winner (mux select)
grant  output  4  one-hot, registered; the requester that owns the word in out_data while out_valid=1
out_valid  output  1  out_data holds an unconsumed word
out_data  output  WIDTH  captured word

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values (immediate, asynchronous): out_valid=0, out_data=0, sel=0, grant=0, ack=0, state=IDLE, ptr=0.
  - ptr is the 2-bit highest-priority index.
- Arbitration (combinational):
  - Scan req starting at ptr, wrapping 3->0.
  - The first set bit is the winner w.
  - If no bit is set, there is no winner.
- State IDLE (out_valid=0):
  - If a winner exists, on the clock edge: out_data<=data_w, sel<=w, grant<=onehot(w), ack<=onehot(w), out_valid<=1, state<=BUSY.
  - Latency from req rise to out_valid is 1 cycle.
  - Otherwise: ack<=0 and the other outputs hold.
- State BUSY (out_valid=1):
  - out_data, sel and grant hold stable until handshake; ack<=0 except as below.
  - Handshake = out_valid & out_ready.
  - On handshake: ptr<=grant index + 1 (mod 4).
  - Arbitration in the handshake cycle uses the updated priority, i.e. scan starts at grant index + 1.
    - If a winner exists: capture it exactly as in IDLE and stay BUSY. This gives back-to-back transfers, 1 word/cycle throughput.
    - If no winner exists: out_valid<=0, grant<=0, state<=IDLE. sel and out_data keep their last values.
  - Without handshake: new requests are ignored. ptr does not change.
- ack semantics:
  - ack[i] pulses for exactly one cycle, coincident with the first cycle out_data holds requester i's word.
  - A requester that keeps req high after its ack is presenting a new word.
- Fairness: a continuously requesting requester waits at most 3 other transfers.
- ptr updates only on handshake, never on capture alone.
- Simultaneous events: if out_ready is high in the same cycle a new req arrives in IDLE, the capture proceeds normally. out_ready has no effect in IDLE.
- Reset mid-transfer: any pending word is dropped, outputs return to reset values, and the next arbitration starts at requester 0.
- Invariants:
  - grant is onehot when out_valid=1 and zero otherwise.
  - ack is at most one-hot.

Test Plan:
1. Reset, then req=0001, data0=A, out_ready=1 -> next cycle out_valid=1, out_data=A, sel=0, grant=0001, ack=0001. Following cycle out_valid=0, ack=0.
2. req=1111 held, data_i=i+5, out_ready=1 -> words 5,6,7,8,5,... on consecutive cycles, sel sequence 0,1,2,3,0, ack rotating one-hot each cycle.
3. Backpressure: req=0100, data2=C, out_ready=0 for 4 cycles -> out_valid=1, out_data=C, grant=0100 held, ack high only the first cycle. Then out_ready=1 -> out_valid drops next cycle (req now 0).
4. Fairness: after grant to requester 3, req=1001 -> next winner is 0, then 3. After grant to 0, req=1001 -> next winner is 3.
5. Assert rst asynchronously mid-BUSY (between edges) -> out_valid=0, out_data=0, sel=0, grant=0 immediately. After release with req=1010 -> winner is 1.
6. Idle gap: single transfer from requester 2, then req=0 for 3 cycles -> out_valid=0, sel=2 retained. Then req=0101 -> winner 0, since ptr=3 and the scan wraps 3->0.
